// File: rtl/mult8_seq_ctrl_if.sv
// Handshake and operand/result bundle for the sequential 8x8 multiplier.
// The master side issues start/a/b; the slave side reports ready/busy/done/product.
interface mult8_seq_ctrl_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// Unsigned 8x8 -> 16 multiplier built by sequencing one 4x4 Wallace core over the
// four nibble partial products, with a start/ready/done handshake.

module wallace_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [3:0] pp [4];
    logic [1:0] h3, h4;
    logic [1:0] f2, f3, f4, f5;
    logic [7:0] row_x, row_y;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = a & {4{b[i]}};
        end
        // Reduce column heights 4 -> 3 -> 2, then one carry-propagate add.
        h3 = ha(pp[0][3], pp[1][2]);
        h4 = ha(pp[1][3], pp[2][2]);
        f2 = fa(pp[0][2], pp[1][1], pp[2][0]);
        f3 = fa(pp[2][1], pp[3][0], h3[0]);
        f4 = fa(pp[3][1], h3[1], h4[0]);
        f5 = fa(pp[2][3], pp[3][2], h4[1]);
        row_x = {1'b0, pp[3][3], f5[0], f4[0], f3[0], f2[0], pp[0][1], pp[0][0]};
        row_y = {1'b0, f5[1], f4[1], f3[1], f2[1], 1'b0, pp[1][0], 1'b0};
        p = row_x + row_y;
    end
endmodule

module mult8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mult8_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        StIdle,
        StPp0,
        StPp1,
        StPp2,
        StPp3,
        StZero,
        StDone
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;

    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;

    wallace_4bit u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Operand nibble select; idle states hold the core inputs at zero.
    always_comb begin
        mul_a = 4'h0;
        mul_b = 4'h0;
        unique case (state_q)
            StPp0: begin mul_a = a_q[3:0]; mul_b = b_q[3:0]; end
            StPp1: begin mul_a = a_q[7:4]; mul_b = b_q[3:0]; end
            StPp2: begin mul_a = a_q[3:0]; mul_b = b_q[7:4]; end
            StPp3: begin mul_a = a_q[7:4]; mul_b = b_q[7:4]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    acc_d = 16'h0000;
                    if (SKIP_ZERO && (bus.a == 8'h00 || bus.b == 8'h00)) begin
                        state_d = StZero;
                    end else begin
                        state_d = StPp0;
                    end
                end
            end
            StPp0: begin
                acc_d   = acc_q + {8'h00, mul_p};
                state_d = StPp1;
            end
            StPp1: begin
                acc_d   = acc_q + {4'h0, mul_p, 4'h0};
                state_d = StPp2;
            end
            StPp2: begin
                acc_d   = acc_q + {4'h0, mul_p, 4'h0};
                state_d = StPp3;
            end
            StPp3: begin
                product_d = acc_q + {mul_p, 8'h00};
                state_d   = StDone;
            end
            StZero: begin
                product_d = 16'h0000;
                state_d   = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            acc_q     <= 16'h0000;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = (state_q == StIdle);
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;
endmodule
